// File: rtl/pairing_seq_pkg.sv
// Shared codes, widths and constants for the pairing command sequencer.
package pairing_seq_pkg;

  localparam int unsigned MODE_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned PC_W_DEF   = 10;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned WDOG_W     = 20;

  // BLS12-381 |x|; bit i is consulted at loop index i.
  localparam logic [63:0]       BLS_LOOP_PATTERN = 64'hd201000000010000;
  localparam logic [WDOG_W-1:0] WDOG_MAX_DEF     = 20'hFFFFF;

  typedef enum logic [1:0] {
    INSTR_EXEC       = 2'b00,
    INSTR_LOOP_BEGIN = 2'b01,
    INSTR_LOOP_END   = 2'b10,
    INSTR_HALT       = 2'b11
  } instr_type_e;

  typedef enum logic [1:0] {
    IM_IDLE             = 2'b00,
    IM_INPUT_COORD_CORE = 2'b01,
    IM_REF_RESULT       = 2'b10,
    IM_EXEC_CORE        = 2'b11
  } inputmode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_GAP    = 3'd4,
    S_HALTED = 3'd5
  } seq_state_e;

  // Command word is {mode, opr1, opr2, ret}.
  function automatic int unsigned cmd_width(input int unsigned mode_w, input int unsigned addr_w);
    return mode_w + 3 * addr_w;
  endfunction

  // ROM word is {type[1:0], cond, cmd}.
  function automatic int unsigned rom_cond_pos(input int unsigned cmd_w);
    return cmd_w;
  endfunction

  function automatic int unsigned rom_type_lsb(input int unsigned cmd_w);
    return cmd_w + 1;
  endfunction

endpackage

// File: rtl/pairing_cmd_sequencer_loop_ctrl.sv
// Single-level loop state: return address, iteration index and condition lookup.
module seq_loop_ctrl
  import pairing_seq_pkg::*;
#(
  parameter int unsigned PC_W         = PC_W_DEF,
  parameter logic [63:0] LOOP_PATTERN = BLS_LOOP_PATTERN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             begin_stb,
  input  logic [PC_W-1:0]  begin_pc,
  input  logic [IDX_W-1:0] begin_n,
  input  logic             end_stb,
  input  logic             query,
  input  logic             cond,
  output logic             in_loop,
  output logic [PC_W-1:0]  loop_pc,
  output logic             idx_zero_c,
  output logic             skip_c
);

  logic [IDX_W-1:0] idx_q;

  assign idx_zero_c = (idx_q == '0);
  // Conditional instruction is dropped when the pattern bit at the current index is 0.
  assign skip_c     = query & cond & in_loop & ~LOOP_PATTERN[idx_q];

  // Loop registers: open on begin, count down on end, close after index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_loop <= 1'b0;
      loop_pc <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      in_loop <= 1'b0;
      loop_pc <= '0;
      idx_q   <= '0;
    end else if (begin_stb) begin
      in_loop <= 1'b1;
      loop_pc <= begin_pc;
      idx_q   <= begin_n - IDX_W'(1);
    end else if (end_stb) begin
      if (idx_q == '0) begin
        in_loop <= 1'b0;
      end else begin
        idx_q <= idx_q - IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/pairing_cmd_sequencer.sv
// Fetches ROM instructions and drives the pairing core command/input mode.
module pairing_cmd_sequencer
  import pairing_seq_pkg::*;
#(
  parameter int unsigned       MODE_W       = MODE_W_DEF,
  parameter int unsigned       ADDR_W       = ADDR_W_DEF,
  parameter int unsigned       PC_W         = PC_W_DEF,
  parameter logic [63:0]       LOOP_PATTERN = BLS_LOOP_PATTERN,
  parameter logic [WDOG_W-1:0] WDOG_MAX     = WDOG_MAX_DEF,
  localparam int unsigned      CMD_W        = cmd_width(MODE_W, ADDR_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [CMD_W+2:0]   rom_data,
  input  logic [1:0]         host_inputmode,
  output logic [1:0]         core_inputmode,
  output logic [CMD_W-1:0]   core_cmd,
  input  logic               core_finished,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned      COND_POS  = rom_cond_pos(CMD_W);
  localparam int unsigned      TYPE_LSB  = rom_type_lsb(CMD_W);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_MAX - WDOG_W'(1);

  seq_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_inc;
  logic [PC_W-1:0]     rom_addr_d;
  logic [CMD_W-1:0]    cmd_d;
  logic [1:0]          im_d;
  logic                busy_d, done_d, err_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                scan_q, scan_d;

  instr_type_e         r_type;
  logic                r_cond;
  logic [CMD_W-1:0]    r_cmd;

  logic                lc_clear, lc_begin, lc_end, lc_query;
  logic                in_loop, idx_zero_c, skip_c;
  logic [PC_W-1:0]     loop_pc;

  assign r_type = instr_type_e'(rom_data[TYPE_LSB +: 2]);
  assign r_cond = rom_data[COND_POS];
  assign r_cmd  = rom_data[CMD_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);

  seq_loop_ctrl #(
    .PC_W         (PC_W),
    .LOOP_PATTERN (LOOP_PATTERN)
  ) u_loop (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (lc_clear),
    .begin_stb  (lc_begin),
    .begin_pc   (pc_inc),
    .begin_n    (r_cmd[IDX_W-1:0]),
    .end_stb    (lc_end),
    .query      (lc_query),
    .cond       (r_cond),
    .in_loop    (in_loop),
    .loop_pc    (loop_pc),
    .idx_zero_c (idx_zero_c),
    .skip_c     (skip_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      wdog_q         <= '0;
      scan_q         <= 1'b0;
      rom_addr       <= '0;
      core_cmd       <= '0;
      core_inputmode <= IM_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      wdog_q         <= wdog_d;
      scan_q         <= scan_d;
      rom_addr       <= rom_addr_d;
      core_cmd       <= cmd_d;
      core_inputmode <= im_d;
      busy           <= busy_d;
      done           <= done_d;
      err            <= err_d;
    end
  end

  // Next state, loop strobes and next output values.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wdog_d   = wdog_q;
    scan_d   = scan_q;
    err_d    = err;
    cmd_d    = core_cmd;
    lc_clear = 1'b0;
    lc_begin = 1'b0;
    lc_end   = 1'b0;
    lc_query = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d     = start_pc;
          err_d    = 1'b0;
          scan_d   = 1'b0;
          lc_clear = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (r_type)
          INSTR_EXEC: begin
            lc_query = 1'b1;
            if (scan_q || skip_c) begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end else begin
              cmd_d   = r_cmd;
              wdog_d  = '0;
              state_d = S_ISSUE;
            end
          end
          INSTR_LOOP_BEGIN: begin
            if (in_loop || scan_q) begin
              err_d   = 1'b1;
              state_d = S_HALTED;
            end else begin
              if (r_cmd[IDX_W-1:0] == '0) scan_d = 1'b1;
              else                        lc_begin = 1'b1;
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          end
          INSTR_LOOP_END: begin
            if (scan_q) begin
              scan_d  = 1'b0;
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end else if (!in_loop) begin
              err_d   = 1'b1;
              state_d = S_HALTED;
            end else begin
              lc_end  = 1'b1;
              pc_d    = idx_zero_c ? pc_inc : loop_pc;
              state_d = S_FETCH;
            end
          end
          INSTR_HALT: state_d = S_HALTED;
        endcase
      end
      S_ISSUE: begin
        if (core_finished) begin
          state_d = S_GAP;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALTED;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_GAP: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    rom_addr_d = (state_d == S_FETCH) ? pc_d : rom_addr;
    if (state_d != S_ISSUE) cmd_d = '0;
    case (state_d)
      S_IDLE:  im_d = host_inputmode;
      S_ISSUE: im_d = IM_EXEC_CORE;
      default: im_d = IM_IDLE;
    endcase
    busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) ||
             (state_d == S_ISSUE) || (state_d == S_GAP);
    done_d = (state_d == S_HALTED);
  end

endmodule

// File: doc/pairing_cmd_sequencer.md
Name: pairing_cmd_sequencer

Overview:
- Upstream controller for the pairing calculation core.
- Fetches encoded instructions from an external program ROM, then drives the core's command word and input-mode select.
- Waits on the core's finished flag, then advances to the next instruction.
- Supports one Miller-loop construct: instructions can be skipped conditionally, based on bits of a fixed loop pattern (BLS12-381 |x|).

Parameters:
- MODE_W, 4, width of core mode field
- ADDR_W, 8, core RAM address width; CMD_W = MODE_W + 3*ADDR_W
- PC_W, 10, program ROM address width
- LOOP_PATTERN, 64'hd201000000010000, loop bit pattern; bit i is consulted at loop index i
- WDOG_MAX, 20'hFFFFF, maximum cycles allowed while waiting on the core

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a program run at start_pc when idle
- start_pc  in  PC_W  first instruction address
- rom_addr  out  PC_W  program ROM read address
- rom_data  in  CMD_W+3  ROM word {type[1:0], cond, cmd}; returned 1 cycle after rom_addr
- host_inputmode  in  2  input mode passed through while idle (load/readout)
- core_inputmode  out  2  input mode to the core
- core_cmd  out  CMD_W  command word {mode, opr1, opr2, ret} to the core
- core_finished  in  1  finished flag from the core
- busy  out  1  high from accepted start until the run ends
- done  out  1  one-cycle pulse on HALT
- err  out  1  sticky error; cleared by the next accepted start

Behaviour:
Reset values:
- All outputs 0; core_inputmode = IDLE code (2'b00); state IDLE; pc, loop registers 0.
- Reset mid-run aborts immediately with no done pulse.

Instruction types:
- EXEC=00: issue cmd.
- LOOP_BEGIN=01: cmd[5:0] = iteration count n.
- LOOP_END=10.
- HALT=11.

States: IDLE, FETCH, DECODE, ISSUE, GAP, HALTED.
- IDLE:
  - core_inputmode = host_inputmode; core_cmd = 0.
  - On start: pc <= start_pc, busy = 1, err = 0, go to FETCH.
  - start while busy is ignored.
- FETCH:
  - rom_addr = pc.
  - Next cycle go to DECODE, with rom_data valid in that cycle.
- DECODE:
  - EXEC with cond=1 while in a loop and LOOP_PATTERN[idx]=0: skip. pc+1, go to FETCH.
  - EXEC otherwise: latch cmd into core_cmd, go to ISSUE.
  - cond=1 outside a loop is treated as unconditional.
  - LOOP_BEGIN:
    - If in_loop is already set (nesting): err=1, go to HALTED.
    - If n=0: skip forward to the instruction after the matching LOOP_END; scan pc+1 via FETCH with EXEC suppressed.
    - Otherwise: loop_pc <= pc+1, idx <= n-1, in_loop=1, pc+1, go to FETCH.
  - LOOP_END:
    - idx>0: idx-1, pc <= loop_pc.
    - idx=0: in_loop=0, pc+1.
    - LOOP_END outside a loop: err=1, go to HALTED.
  - HALT: go to HALTED.
- ISSUE:
  - core_inputmode = EXEC_CORE (2'b11); core_cmd held stable.
  - Watchdog counts each cycle.
  - core_finished=1: go to GAP.
  - Watchdog reaches WDOG_MAX: err=1, go to HALTED.
- GAP:
  - Exactly one cycle with core_inputmode = IDLE and core_cmd = 0, so the core returns to state 0.
  - pc+1, go to FETCH.
- HALTED:
  - done=1 for one cycle, busy=0, go to IDLE.
- pc wraps modulo 2^PC_W silently.

Latency:
- Issue overhead per EXEC: 4 cycles beyond the core's own latency (FETCH, DECODE, GAP, plus 1 finished-sampling cycle).
- Skipped EXEC: 2 cycles.
- core_finished is ignored outside ISSUE.

Decomposition:
- Shared package pairing_seq_pkg:
  - instruction type codes
  - input-mode codes (IDLE, INPUT_COORD_CORE, REF_RESULT, EXEC_CORE)
  - CMD_W derivation
  - ROM word field offsets
  - BLS12-381 LOOP_PATTERN constant
- One natural sub-module, seq_loop_ctrl: holds loop_pc, idx and in_loop, and evaluates the condition bit, taking begin/end/query strobes.

Test Plan:
- Single EXEC at pc=0 (mode=PDBL, 0x01,0x02,0x03), then HALT; core model finishes after 10 cycles → core_cmd held 10 cycles with EXEC_CORE, one GAP cycle, done at cycle 16, busy low after.
- LOOP_BEGIN n=4, EXEC A, EXEC B cond=1, LOOP_END, HALT, with LOOP_PATTERN=4'b1010 → issue order A,B,A,A,B,A; B skipped at idx 2 and 0.
- Nested LOOP_BEGIN → err=1, done pulse, no further core_cmd issued; next start clears err.
- Core never asserts finished, WDOG_MAX=100 → err=1 exactly 100 cycles after ISSUE entry; core_inputmode returns to host passthrough.
- Idle passthrough: host_inputmode=REF_RESULT → core_inputmode=REF_RESULT; a start pulse while busy is ignored and pc is unchanged.
- rst_n asserted mid-ISSUE → all outputs 0 asynchronously; a fresh start re-runs the program correctly.
